// File: rtl/ula_pkg.sv
// Shared types for the ALU output stage: result width, FIFO entry layout and occupancy states.
package ula_pkg;

   localparam int unsigned LARGURA_ULA = 8;

   // Entry layout; the top packs the same field order into a LARGURA+3 vector.
   typedef struct packed {
      logic                   carry;
      logic                   zero;
      logic                   neg;
      logic [LARGURA_ULA-1:0] data;
   } ula_entrada_t;

   typedef enum logic [1:0] {
      VAZIO   = 2'd0,
      PARCIAL = 2'd1,
      CHEIO   = 2'd2
   } ocupacao_e;

endpackage

// File: rtl/ula_fifo.sv
// Generic FIFO storage with count-based occupancy FSM; clear has priority over push/pop.
module ula_fifo
   import ula_pkg::*;
#(
   parameter int unsigned LARGURA      = 11,
   parameter int unsigned PROFUNDIDADE = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            limpar,
   input  logic                            push,
   input  logic                            pop,
   input  logic [LARGURA-1:0]              din,
   output logic [LARGURA-1:0]              dout,
   output logic [$clog2(PROFUNDIDADE):0]   contagem,
   output ocupacao_e                       estado
);

   localparam int unsigned AW = $clog2(PROFUNDIDADE);
   localparam logic [AW:0] C_CHEIO  = (AW+1)'(PROFUNDIDADE);
   localparam logic [AW:0] C_QUASE  = (AW+1)'(PROFUNDIDADE - 1);
   localparam logic [AW:0] C_UM     = (AW+1)'(1);
   localparam logic [AW-1:0] P_UM   = AW'(1);

   logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
   logic [AW-1:0]      r_wr;
   logic [AW-1:0]      r_rd;
   logic [AW:0]        r_cont;
   ocupacao_e          r_estado;

   logic w_push;
   logic w_pop;

   assign w_push = push & (r_estado != CHEIO) & ~limpar;
   assign w_pop  = pop  & (r_estado != VAZIO) & ~limpar;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr     <= '0;
         r_rd     <= '0;
         r_cont   <= '0;
         r_estado <= VAZIO;
      end else if (limpar) begin
         r_wr     <= '0;
         r_rd     <= '0;
         r_cont   <= '0;
         r_estado <= VAZIO;
      end else begin
         if (w_push) r_wr <= r_wr + P_UM;
         if (w_pop)  r_rd <= r_rd + P_UM;
         case ({w_push, w_pop})
            2'b10: begin
               r_cont   <= r_cont + C_UM;
               r_estado <= (r_cont == C_QUASE) ? CHEIO : PARCIAL;
            end
            2'b01: begin
               r_cont   <= r_cont - C_UM;
               r_estado <= (r_cont == C_UM) ? VAZIO : PARCIAL;
            end
            default: ;
         endcase
      end
   end

   // Head is forced to zero when empty so stale storage never leaks out.
   assign dout     = (r_estado == VAZIO) ? '0 : r_mem[r_rd];
   assign contagem = r_cont;
   assign estado   = r_estado;

   logic w_unused_cheio;
   assign w_unused_cheio = ^C_CHEIO;

endmodule

// File: rtl/ula_registro_saida.sv
// ALU output stage: flags, result FIFO and feedback accumulator.
// Optional ULA_STATUS_EN adds ocupacao (FIFO count) and sticky carry_fixo outputs.
module ula_registro_saida
   import ula_pkg::*;
#(
   parameter int unsigned LARGURA      = LARGURA_ULA,
   parameter int unsigned PROFUNDIDADE = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          limpar,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LARGURA-1:0]            resultado,
   input  logic                          carry_out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LARGURA-1:0]            out_dado,
   output logic                          out_carry,
   output logic                          out_zero,
   output logic                          out_neg,
   output logic [LARGURA-1:0]            acc,
   output logic                          acc_carry
`ifdef ULA_STATUS_EN
   ,
   output logic [$clog2(PROFUNDIDADE):0] ocupacao,
   output logic                          carry_fixo
`endif
);

   localparam int unsigned LE = LARGURA + 3;

   logic [LE-1:0]                  w_entrada;
   logic [LE-1:0]                  w_cabeca;
   logic [$clog2(PROFUNDIDADE):0]  w_contagem;
   ocupacao_e                      w_estado;
   logic                           w_push;
   logic                           w_pop;
   logic [LARGURA-1:0]             r_acc;
   logic                           r_acc_carry;

   // Flags are fixed at push time: {carry, zero, neg, data}.
   assign w_entrada = {carry_out, (resultado == '0), resultado[LARGURA-1], resultado};

   assign in_ready  = (w_estado != CHEIO);
   assign out_valid = (w_estado != VAZIO);
   assign w_push    = in_valid & in_ready & ~limpar;
   assign w_pop     = out_valid & out_ready & ~limpar;

   ula_fifo #(
      .LARGURA      (LE),
      .PROFUNDIDADE (PROFUNDIDADE)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .limpar   (limpar),
      .push     (w_push),
      .pop      (w_pop),
      .din      (w_entrada),
      .dout     (w_cabeca),
      .contagem (w_contagem),
      .estado   (w_estado)
   );

   assign out_carry = w_cabeca[LE-1];
   assign out_zero  = w_cabeca[LE-2];
   assign out_neg   = w_cabeca[LE-3];
   assign out_dado  = w_cabeca[LARGURA-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_acc_carry <= 1'b0;
      end else if (limpar) begin
         r_acc       <= '0;
         r_acc_carry <= 1'b0;
      end else if (w_push) begin
         r_acc       <= resultado;
         r_acc_carry <= carry_out;
      end
   end

   assign acc       = r_acc;
   assign acc_carry = r_acc_carry;

`ifdef ULA_STATUS_EN
   logic r_carry_fixo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_carry_fixo <= 1'b0;
      else if (limpar)              r_carry_fixo <= 1'b0;
      else if (w_push && carry_out) r_carry_fixo <= 1'b1;
   end

   assign ocupacao   = w_contagem;
   assign carry_fixo = r_carry_fixo;
`else
   logic w_unused_contagem;
   assign w_unused_contagem = ^w_contagem;
`endif

endmodule

// File: tb/tb_ula_registro_saida.sv
// Directed bench for ula_registro_saida; build with +define+ULA_STATUS_EN to cover the status outputs.
module tb_ula_registro_saida;

   logic       clk = 1'b0;
   logic       rst;
   logic       limpar;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] resultado;
   logic       carry_out;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_dado;
   logic       out_carry;
   logic       out_zero;
   logic       out_neg;
   logic [7:0] acc;
   logic       acc_carry;
`ifdef ULA_STATUS_EN
   logic [1:0] ocupacao;
   logic       carry_fixo;
`endif

   int n_checks = 0;
   int n_erros  = 0;

   always #5 clk = ~clk;

   ula_registro_saida #(
      .LARGURA      (8),
      .PROFUNDIDADE (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .limpar     (limpar),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .resultado  (resultado),
      .carry_out  (carry_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_dado   (out_dado),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .acc        (acc),
      .acc_carry  (acc_carry)
`ifdef ULA_STATUS_EN
      ,
      .ocupacao   (ocupacao),
      .carry_fixo (carry_fixo)
`endif
   );

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_checks++;
      if (obs !== esp) begin
         n_erros++;
         $display("FAIL %s obs=0x%0h esp=0x%0h", tag, obs, esp);
      end
   endtask

   // Applies inputs at a falling edge for one rising edge, then idles them.
   task automatic ciclo(input logic v, input logic [7:0] r, input logic c,
                        input logic ordy, input logic lmp);
      in_valid  = v;
      resultado = r;
      carry_out = c;
      out_ready = ordy;
      limpar    = lmp;
      @(negedge clk);
      in_valid  = 1'b0;
      resultado = 8'h00;
      carry_out = 1'b0;
      out_ready = 1'b0;
      limpar    = 1'b0;
   endtask

   initial begin
      logic [7:0] v;
      rst = 1'b1; limpar = 1'b0; in_valid = 1'b0; resultado = 8'h00;
      carry_out = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      verifica("rst_in_ready", in_ready, 1);
      verifica("rst_out_valid", out_valid, 0);
      verifica("rst_acc", acc, 8'h00);
      verifica("rst_acc_carry", acc_carry, 0);
      verifica("rst_out_dado", out_dado, 8'h00);

      // single transfer
      ciclo(1, 8'h80, 1, 0, 0);
      verifica("t1_valid", out_valid, 1);
      verifica("t1_dado", out_dado, 8'h80);
      verifica("t1_neg", out_neg, 1);
      verifica("t1_zero", out_zero, 0);
      verifica("t1_carry", out_carry, 1);
      verifica("t1_acc", acc, 8'h80);
      verifica("t1_acc_carry", acc_carry, 1);
      ciclo(0, 8'h00, 0, 1, 0);
      verifica("t1_pop_valid", out_valid, 0);
      verifica("t1_pop_dado", out_dado, 8'h00);
      verifica("t1_acc_keep", acc, 8'h80);

      // fill and stall
      ciclo(1, 8'h00, 0, 0, 0);
      verifica("t2_ready1", in_ready, 1);
      verifica("t2_zero1", out_zero, 1);
      ciclo(1, 8'h05, 0, 0, 0);
      verifica("t2_full_ready", in_ready, 0);
      verifica("t2_head", out_dado, 8'h00);
      verifica("t2_head_zero", out_zero, 1);
      verifica("t2_acc", acc, 8'h05);
      ciclo(1, 8'h07, 1, 0, 0);
      verifica("t2_ign_ready", in_ready, 0);
      verifica("t2_ign_head", out_dado, 8'h00);
      verifica("t2_ign_acc", acc, 8'h05);
      verifica("t2_ign_accc", acc_carry, 0);
      ciclo(1, 8'h07, 1, 1, 0);
      verifica("t2_pop1_head", out_dado, 8'h05);
      verifica("t2_pop1_zero", out_zero, 0);
      verifica("t2_pop1_ready", in_ready, 1);
      verifica("t2_pop1_acc", acc, 8'h05);
      ciclo(0, 8'h00, 0, 1, 0);
      verifica("t2_pop2_valid", out_valid, 0);
      verifica("t2_pop2_acc", acc, 8'h05);

      // simultaneous push/pop with pointer wrap
      ciclo(1, 8'h11, 0, 0, 0);
      verifica("t3_head0", out_dado, 8'h11);
      for (int i = 0; i < 5; i++) begin
         v = 8'h22 + 8'(i) * 8'h11;
         ciclo(1, v, 0, 1, 0);
         verifica("t3_head", out_dado, v);
         verifica("t3_valid", out_valid, 1);
         verifica("t3_ready", in_ready, 1);
`ifdef ULA_STATUS_EN
         verifica("t3_ocup", ocupacao, 1);
`endif
      end
      verifica("t3_acc", acc, 8'h66);
      ciclo(0, 8'h00, 0, 1, 0);
      verifica("t3_empty", out_valid, 0);

      // limpar with 2 entries, push and pop requested
      ciclo(1, 8'hAA, 1, 0, 0);
      ciclo(1, 8'hBB, 0, 0, 0);
      verifica("t4_full", in_ready, 0);
      ciclo(1, 8'hCC, 1, 1, 1);
      verifica("t4_valid", out_valid, 0);
      verifica("t4_acc", acc, 8'h00);
      verifica("t4_accc", acc_carry, 0);
      verifica("t4_ready", in_ready, 1);
      verifica("t4_dado", out_dado, 8'h00);
      ciclo(1, 8'hDD, 0, 0, 0);
      verifica("t4_after_head", out_dado, 8'hDD);
      ciclo(0, 8'h00, 0, 1, 0);
      verifica("t4_after_empty", out_valid, 0);

      // asynchronous reset mid-cycle
      ciclo(1, 8'h3C, 1, 0, 0);
      verifica("t5_pre_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      verifica("t5_rst_ready", in_ready, 1);
      verifica("t5_rst_valid", out_valid, 0);
      verifica("t5_rst_acc", acc, 8'h00);
      verifica("t5_rst_accc", acc_carry, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      verifica("t5_post_valid", out_valid, 0);

`ifdef ULA_STATUS_EN
      ciclo(1, 8'h01, 0, 0, 0);
      verifica("t6_ocup1", ocupacao, 1);
      verifica("t6_fixo1", carry_fixo, 0);
      ciclo(1, 8'h02, 1, 0, 0);
      verifica("t6_ocup2", ocupacao, 2);
      verifica("t6_fixo2", carry_fixo, 1);
      ciclo(0, 8'h00, 0, 1, 0);
      verifica("t6_ocup_pop", ocupacao, 1);
      ciclo(1, 8'h03, 0, 0, 0);
      verifica("t6_ocup3", ocupacao, 2);
      verifica("t6_fixo3", carry_fixo, 1);
      ciclo(0, 8'h00, 0, 0, 1);
      verifica("t6_clr_ocup", ocupacao, 0);
      verifica("t6_clr_fixo", carry_fixo, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
      $finish;
   end

endmodule

// File: doc/ula_registro_saida.md
Name: ula_registro_saida

Overview:
- Downstream stage of the 8-bit ALU.
- Captures each ALU result and its carry-out through a valid/ready handshake, derives status flags, and buffers results in a small FIFO for the consumer.
- Also holds an accumulator (result + carry) that is fed back as the ALU's A operand and carry_in, enabling chained and multi-byte operations.

Parameters:
- LARGURA, 8, data width; matches the ALU result width.
- PROFUNDIDADE, 2, FIFO depth in entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- limpar  input  1  synchronous clear of FIFO, accumulator and status.
- in_valid  input  1  ALU result presented.
- in_ready  output  1  stage can accept a result.
- resultado  input  LARGURA  ALU result.
- carry_out  input  1  ALU carry-out.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes the head entry.
- out_dado  output  LARGURA  head data.
- out_carry  output  1  head carry flag.
- out_zero  output  1  head zero flag.
- out_neg  output  1  head sign flag (MSB).
- acc  output  LARGURA  accumulator; drives ALU operand A.
- acc_carry  output  1  accumulated carry; drives ALU carry_in.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; pointers and count = 0.
  - acc = 0, acc_carry = 0.
  - out_valid = 0, out_dado/flags = 0.
  - in_ready = 1.
- Occupancy FSM:
  - States: VAZIO (count=0), PARCIAL (0<count<PROFUNDIDADE), CHEIO (count=PROFUNDIDADE).
  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged.
- in_ready:
  - Registered-equivalent: in_ready = (state != CHEIO).
  - No combinational path from out_ready to in_ready.
  - When CHEIO, a same-cycle pop does not enable a push.
- Push (in_valid & in_ready):
  - Entry = {carry_out, resultado==0, resultado[LARGURA-1], resultado}, written at the write pointer.
  - Flags are computed at push time, not at pop.
- Pop (out_valid & out_ready):
  - Read pointer advances.
  - out_* always reflect the head entry combinationally from storage; 0 when VAZIO.
- Latency: a pushed entry is visible on out_* the cycle after acceptance (1-cycle latency, no bypass when empty).
- Pointers:
  - Width $clog2(PROFUNDIDADE).
  - Wrap modulo PROFUNDIDADE.
  - Full/empty decided by count, not pointer compare.
- Accumulator:
  - On every push: acc <= resultado, acc_carry <= carry_out.
  - Unchanged otherwise; independent of pops.
- limpar:
  - Highest synchronous priority: FIFO emptied, acc = 0, acc_carry = 0.
  - A push or pop in the same cycle is discarded.
  - in_ready = 1 the next cycle.
- rst mid-operation: all state is lost immediately, including stored entries; no partial push survives.
- Handshake stability:
  - out_valid, once high, stays high until popped or cleared.
  - Head data is stable while out_valid=1 and out_ready=0.
- Invalid protocol: in_valid while in_ready=0 is ignored, with no state change.

Optional Feature:
- Macro: ULA_STATUS_EN.
- Defined: adds output ocupacao [$clog2(PROFUNDIDADE):0], equal to the current count, and output carry_fixo (1 bit, sticky).
  - carry_fixo is set on any push with carry_out=1.
  - It is cleared only by rst or limpar; reset value 0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ula_pkg:
  - LARGURA_ULA = 8.
  - Entry struct type: carry, zero, neg, data.
  - Occupancy state enum: VAZIO, PARCIAL, CHEIO.
- One natural sub-module, ula_fifo: generic storage, pointers and count, parameterised by width/depth, with push/pop/clear.
  - The top module adds flag generation, the accumulator and the optional status.

Test Plan:
- Reset then idle: rst=1 asserted async mid-cycle -> in_ready=1, out_valid=0, acc=0x00, acc_carry=0 immediately.
- Single transfer: push resultado=0x80, carry_out=1 -> next cycle out_valid=1, out_dado=0x80, out_neg=1, out_zero=0, out_carry=1, acc=0x80, acc_carry=1; pop -> out_valid=0.
- Fill and stall: push 0x00 then 0x05 with out_ready=0 -> in_ready=0 (CHEIO), head out_zero=1.
  - Third push of 0x07 is ignored.
  - Pop twice -> 0x00 then 0x05 in order.
  - acc=0x05 throughout, never 0x07.
- Simultaneous push/pop in PARCIAL with 1 entry 0x11, push 0x22 -> count stays 1, next head 0x22.
  - Repeat 5 times to exercise pointer wrap; order preserved.
- limpar with in_valid=1, out_ready=1 and 2 entries held -> next cycle out_valid=0, acc=0, in_ready=1; the pushed value is absent.
- ULA_STATUS_EN defined: push carry 0,1,0 -> carry_fixo=1 after the second push and stays 1; ocupacao tracks 1,2; limpar -> both 0.
